// File: rtl/huffman_control_if.sv
// Token output channel of the Huffman decoder sequencer: one {run, size, coeff, index, eob}
// token per decoded symbol, transferred on out_valid & out_ready.
interface huffman_control_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_run;
  logic [3:0] out_size;
  logic [9:0] out_coeff;
  logic [5:0] out_index;
  logic       out_eob;

  modport master (
    output out_valid, out_run, out_size, out_coeff, out_index, out_eob,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_run, out_size, out_coeff, out_index, out_eob,
    output out_ready
  );
endinterface

// File: rtl/huffman_control.sv
// Huffman decoder sequencer: walks code bits, looks up run/size, collects coefficient bits,
// and emits one token per symbol while tracking the position inside the 8x8 block.
module huffman_control #(
  parameter int MAX_CODE_LEN = 9,
  parameter int BLOCK_SIZE   = 64
) (
  input  logic              phi1,
  input  logic              reset,
  input  logic              bit_valid_s1,
  output logic              bit_ready_s1,
  output logic              reset_sr_s2,
  output logic              coeff_en_b_s2,
  input  logic              match_s1,
  output logic [3:0]        code_length_s1,
  input  logic [3:0]        coeff_size_v1,
  input  logic [3:0]        run_length_v1,
  input  logic [9:0]        coefficient_s2,
  huffman_control_if.master tok,
  output logic              error
);

  localparam logic [3:0] MAX_LEN = 4'(MAX_CODE_LEN);
  localparam logic [6:0] BLK     = 7'(BLOCK_SIZE);

  typedef enum logic [2:0] {
    S_CODE,
    S_LOOKUP,
    S_COEFF,
    S_CAPT,
    S_OUTPUT,
    S_ERROR
  } state_t;

  state_t     state, state_d;
  logic [3:0] code_len;
  logic [3:0] remaining;
  logic       first_bit;
  logic [5:0] index;

  logic [3:0] run_p1;
  logic [3:0] size_p1;
  logic [9:0] coeff_p2;
  logic [5:0] idx_p1;
  logic       eob_p1;

  logic       code_hit;
  logic       accept;
  logic       handshake;
  logic       entering;
  logic [6:0] idx_sum;

  // ZRL carries run=15, so run+1 already yields the 16-position skip.
  function automatic logic [6:0] next_index(input logic [5:0] idx, input logic [3:0] run,
                                            input logic eob);
    if (eob) next_index = 7'd0;
    else     next_index = {1'b0, idx} + {3'b000, run} + 7'd1;
  endfunction

  function automatic logic [5:0] wrap_index(input logic [6:0] sum);
    wrap_index = (sum >= BLK) ? 6'd0 : sum[5:0];
  endfunction

  // match_s1 reflects the bits shifted on the previous edge, so it is only meaningful from length 2.
  assign code_hit       = (code_len >= 4'd2) && match_s1;

  always_comb begin
    bit_ready_s1 = 1'b0;
    if (bit_valid_s1) begin
      if (state == S_CODE)       bit_ready_s1 = !code_hit;
      else if (state == S_COEFF) bit_ready_s1 = 1'b1;
    end
  end

  assign accept         = bit_ready_s1;
  assign reset_sr_s2    = bit_ready_s1 && first_bit;
  assign coeff_en_b_s2  = (state != S_COEFF);
  assign code_length_s1 = code_len;
  assign error          = (state == S_ERROR);
  assign handshake      = (state == S_OUTPUT) && tok.out_ready;
  assign idx_sum        = next_index(index, run_p1, eob_p1);
  assign entering       = (state_d != state) && ((state_d == S_CODE) || (state_d == S_COEFF));

  assign tok.out_valid  = (state == S_OUTPUT);
  assign tok.out_run    = run_p1;
  assign tok.out_size   = size_p1;
  assign tok.out_coeff  = coeff_p2;
  assign tok.out_index  = idx_p1;
  assign tok.out_eob    = eob_p1;

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) state <= S_CODE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_CODE: begin
        if (code_hit)                 state_d = S_LOOKUP;
        else if (code_len == MAX_LEN) state_d = S_ERROR;
      end
      S_LOOKUP: begin
        if (coeff_size_v1 != 4'd0)                                  state_d = S_COEFF;
        else if ((run_length_v1 == 4'd0) || (run_length_v1 == 4'd15)) state_d = S_OUTPUT;
        else                                                        state_d = S_ERROR;
      end
      S_COEFF: begin
        if (accept && (remaining == 4'd1)) state_d = S_CAPT;
      end
      S_CAPT:   state_d = S_OUTPUT;
      S_OUTPUT: begin
        if (handshake) state_d = (idx_sum > BLK) ? S_ERROR : S_CODE;
      end
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase
  end

  // ---- stage p0: sequencing counters ----
  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      code_len  <= 4'd0;
      remaining <= 4'd0;
      first_bit <= 1'b1;
      index     <= 6'd0;
    end else begin
      if (state == S_LOOKUP)
        code_len <= 4'd0;
      else if ((state == S_CODE) && accept && (code_len < MAX_LEN))
        code_len <= code_len + 4'd1;

      if (state == S_LOOKUP)
        remaining <= coeff_size_v1;
      else if ((state == S_COEFF) && accept)
        remaining <= remaining - 4'd1;

      if (entering)    first_bit <= 1'b1;
      else if (accept) first_bit <= 1'b0;

      if (handshake) index <= wrap_index(idx_sum);
    end
  end

  // ---- stage p1: token header from the Table 2 lookup ----
  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      run_p1  <= 4'd0;
      size_p1 <= 4'd0;
      idx_p1  <= 6'd0;
      eob_p1  <= 1'b0;
    end else if (state == S_LOOKUP) begin
      run_p1  <= run_length_v1;
      size_p1 <= coeff_size_v1;
      idx_p1  <= index + {2'b00, run_length_v1};
      eob_p1  <= (coeff_size_v1 == 4'd0) && (run_length_v1 == 4'd0);
    end
  end

  // ---- stage p2: coefficient latched once the datapath has the final bit ----
  always_ff @(posedge phi1 or posedge reset) begin
    if (reset)                  coeff_p2 <= 10'd0;
    else if (state == S_LOOKUP) coeff_p2 <= 10'd0;
    else if (state == S_CAPT)   coeff_p2 <= coefficient_s2;
  end

endmodule

// File: tb/tb_huffman_control.sv
// Directed bench for huffman_control with a small datapath/table model and a token scoreboard.
module tb_huffman_control;

  logic       phi1 = 1'b0;
  logic       reset;
  logic       bit_valid_s1;
  logic       bit_ready_s1;
  logic       reset_sr_s2;
  logic       coeff_en_b_s2;
  logic       match_s1;
  logic [3:0] code_length_s1;
  logic [3:0] coeff_size_v1;
  logic [3:0] run_length_v1;
  logic [9:0] coefficient_s2;
  logic       error;

  huffman_control_if tok();

  huffman_control #(.MAX_CODE_LEN(9), .BLOCK_SIZE(64)) dut (
    .phi1           (phi1),
    .reset          (reset),
    .bit_valid_s1   (bit_valid_s1),
    .bit_ready_s1   (bit_ready_s1),
    .reset_sr_s2    (reset_sr_s2),
    .coeff_en_b_s2  (coeff_en_b_s2),
    .match_s1       (match_s1),
    .code_length_s1 (code_length_s1),
    .coeff_size_v1  (coeff_size_v1),
    .run_length_v1  (run_length_v1),
    .coefficient_s2 (coefficient_s2),
    .tok            (tok),
    .error          (error)
  );

  always #5 phi1 = ~phi1;

  // Datapath model: 10-bit shift register plus a prefix-free code table.
  logic       bitstream;
  logic [9:0] sr = '0;
  logic [8:0] hitv;

  always_ff @(posedge phi1)
    if (bit_ready_s1) sr <= reset_sr_s2 ? {9'b0, bitstream} : {sr[8:0], bitstream};

  function automatic logic [8:0] lookup(input logic [3:0] cl, input logic [9:0] s);
    logic [9:0] m;
    m = s & ((10'd1 << cl) - 10'd1);
    lookup = 9'd0;
    case (cl)
      4'd2: if (m == 10'b00)         lookup = {1'b1, 4'd1,  4'd3};
            else if (m == 10'b01)    lookup = {1'b1, 4'd0,  4'd0};
      4'd3: if (m == 10'b100)        lookup = {1'b1, 4'd15, 4'd0};
            else if (m == 10'b101)   lookup = {1'b1, 4'd2,  4'd1};
      4'd4: if (m == 10'b1100)       lookup = {1'b1, 4'd11, 4'd2};
            else if (m == 10'b1101)  lookup = {1'b1, 4'd5,  4'd1};
      4'd5: if (m == 10'b11100)      lookup = {1'b1, 4'd3,  4'd0};
            else if (m == 10'b11101) lookup = {1'b1, 4'd0,  4'd2};
      default: lookup = 9'd0;
    endcase
  endfunction

  always_comb begin
    hitv           = lookup(code_length_s1, sr);
    match_s1       = hitv[8];
    run_length_v1  = hitv[7:4];
    coeff_size_v1  = hitv[3:0];
    coefficient_s2 = sr;
  end

  typedef struct packed {
    logic [3:0] run;
    logic [3:0] size;
    logic [9:0] coeff;
    logic [5:0] idx;
    logic       eob;
  } tok_t;

  logic bitq[$];
  tok_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  int   gcyc = 0, last_acc = 0, n_rsr = 0, n_cacc = 0, hold_left = 0;
  int   exp_idx = 0;
  bit   lat_chk = 0;
  logic exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bits(input logic [9:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bitq.push_back(v[i]);
  endtask

  task automatic expect_tok(input logic [3:0] run, input logic [3:0] size,
                            input logic [9:0] coeff, input logic eob);
    tok_t t;
    int   nxt;
    t.run = run; t.size = size; t.coeff = coeff; t.eob = eob;
    t.idx = 6'((exp_idx + int'(run)) % 64);
    if (eob) exp_idx = 0;
    else begin
      nxt = exp_idx + int'(run) + 1;
      if (nxt == 64)     exp_idx = 0;
      else if (nxt > 64) exp_err = 1'b1;
      else               exp_idx = nxt;
    end
    sb.push_back(t);
  endtask

  task automatic sym_coef(input logic [9:0] code, input int clen, input logic [3:0] run,
                          input logic [3:0] size, input logic [9:0] cbits);
    push_bits(code, clen);
    push_bits(cbits, int'(size));
    expect_tok(run, size, cbits, 1'b0);
  endtask

  task automatic sym_eob();
    push_bits(10'b01, 2);
    expect_tok(4'd0, 4'd0, 10'd0, 1'b1);
  endtask

  task automatic sym_zrl();
    push_bits(10'b100, 3);
    expect_tok(4'd15, 4'd0, 10'd0, 1'b0);
  endtask

  task automatic run(input int budget, input bit until_idle, input bit toggle);
    bit   done, prev_valid, snap;
    tok_t cur, snapv, ex;
    done = 0; prev_valid = 0; snap = 0; snapv = '0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge phi1);
      bit_valid_s1  = (bitq.size() > 0) && (!toggle || (cyc % 2 == 1));
      bitstream     = (bitq.size() > 0) ? bitq[0] : 1'b0;
      tok.out_ready = (hold_left == 0);
      #1;
      cur.run = tok.out_run; cur.size = tok.out_size; cur.coeff = tok.out_coeff;
      cur.idx = tok.out_index; cur.eob = tok.out_eob;
      if (bit_ready_s1) begin
        void'(bitq.pop_front());
        last_acc = gcyc;
        if (reset_sr_s2) n_rsr++;
        if (!coeff_en_b_s2) n_cacc++;
      end
      if (tok.out_valid) begin
        if (bit_valid_s1) check("no_bit_during_output", 32'(bit_ready_s1), 32'd0);
        if (lat_chk && !prev_valid) check("latency", 32'(gcyc - last_acc), 32'd2);
        if (!tok.out_ready) begin
          if (snap) check("stall_stable", 32'(cur), 32'(snapv));
          snapv = cur; snap = 1; hold_left--;
        end else begin
          check("token_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            ex = sb.pop_front();
            check("token", 32'(cur), 32'(ex));
          end
          snap = 0;
        end
      end
      prev_valid = tok.out_valid;
      gcyc++;
      if (until_idle && bitq.size() == 0 && sb.size() == 0 && !(tok.out_valid && !tok.out_ready))
        done = 1;
    end
    if (until_idle) check("run_done", 32'(done), 32'd1);
    @(posedge phi1);
    #1;
    bit_valid_s1 = 1'b0; tok.out_ready = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_bit_ready"}, 32'(bit_ready_s1), 32'd0);
    check({tag, "_reset_sr"}, 32'(reset_sr_s2), 32'd0);
    check({tag, "_coeff_en_b"}, 32'(coeff_en_b_s2), 32'd1);
    check({tag, "_code_length"}, 32'(code_length_s1), 32'd0);
    check({tag, "_out_valid"}, 32'(tok.out_valid), 32'd0);
    check({tag, "_out_fields"}, 32'({tok.out_run, tok.out_size, tok.out_coeff, tok.out_index, tok.out_eob}), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge phi1);
    reset = 1'b1; bit_valid_s1 = 1'b0; tok.out_ready = 1'b0;
    @(negedge phi1);
    reset = 1'b0;
    bitq.delete(); sb.delete(); exp_idx = 0; exp_err = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bit_valid_s1 = 1'b0; bitstream = 1'b0; tok.out_ready = 1'b0;
    repeat (2) @(negedge phi1);
    reset = 1'b0;
    #1;
    check_reset("por");

    // code 00 -> run 1 size 3, coefficient 101
    lat_chk = 1; n_rsr = 0; n_cacc = 0;
    sym_coef(10'b00, 2, 4'd1, 4'd3, 10'b101);
    run(60, 1, 0);
    check("reset_sr_pulses", 32'(n_rsr), 32'd2);
    check("coeff_phase_bits", 32'(n_cacc), 32'd3);
    lat_chk = 0;

    // walk to index 10, EOB, then a run-0 token at index 0
    sym_coef(10'b1101, 4, 4'd5, 4'd1, 10'b1);
    sym_coef(10'b00, 2, 4'd1, 4'd3, 10'b010);
    sym_eob();
    sym_coef(10'b11101, 5, 4'd0, 4'd2, 10'b10);
    sym_eob();
    run(300, 1, 0);

    // two ZRL then run 2, with bit_valid toggling
    sym_zrl(); sym_zrl();
    sym_coef(10'b101, 3, 4'd2, 4'd1, 10'b1);
    sym_eob();
    run(400, 1, 1);

    // downstream stall for 5 cycles
    hold_left = 5;
    sym_coef(10'b00, 2, 4'd1, 4'd3, 10'b011);
    sym_coef(10'b101, 3, 4'd2, 4'd1, 10'b0);
    sym_eob();
    run(300, 1, 0);
    check("hold_consumed", 32'(hold_left), 32'd0);

    // exact wrap at 64
    sym_zrl(); sym_zrl(); sym_zrl();
    sym_coef(10'b1100, 4, 4'd11, 4'd2, 10'b11);
    sym_coef(10'b00, 2, 4'd1, 4'd3, 10'b100);
    sym_coef(10'b11101, 5, 4'd0, 4'd2, 10'b01);
    sym_coef(10'b11101, 5, 4'd0, 4'd2, 10'b10);
    sym_coef(10'b11101, 5, 4'd0, 4'd2, 10'b11);
    sym_eob();
    run(600, 1, 0);
    check("no_error_after_wrap", 32'(error), 32'(exp_err));

    // index 60 plus run 5 overflows
    sym_zrl(); sym_zrl(); sym_zrl();
    sym_coef(10'b1100, 4, 4'd11, 4'd2, 10'b01);
    sym_coef(10'b1101, 4, 4'd5, 4'd1, 10'b1);
    run(400, 1, 0);
    run(3, 0, 0);
    check("overflow_error", 32'(error), 32'(exp_err));
    push_bits(10'b1010, 4);
    run(6, 0, 0);
    check("error_no_consume", 32'(bitq.size()), 32'd4);
    check("error_sticky", 32'(error), 32'd1);

    // nine bits without a match
    do_reset();
    push_bits(10'b111111111, 9);
    run(30, 1, 0);
    run(3, 0, 0);
    check("no_match_error", 32'(error), 32'd1);
    push_bits(10'b11, 2);
    run(5, 0, 0);
    check("no_match_sticky", 32'(error), 32'd1);

    // size 0 with run 3 is illegal
    do_reset();
    push_bits(10'b11100, 5);
    run(30, 1, 0);
    run(3, 0, 0);
    check("bad_run_error", 32'(error), 32'd1);

    // reset in the middle of a coefficient
    do_reset();
    push_bits(10'b00, 2);
    push_bits(10'b1, 1);
    run(10, 0, 0);
    check("mid_coeff_phase", 32'(coeff_en_b_s2), 32'd0);
    check("mid_coeff_no_token", 32'(tok.out_valid), 32'd0);
    @(negedge phi1);
    reset = 1'b1;
    #1;
    check_reset("async_rst");
    @(negedge phi1);
    reset = 1'b0;
    #1;
    check_reset("post_rst");
    bitq.delete(); sb.delete(); exp_idx = 0; exp_err = 1'b0;
    sym_coef(10'b101, 3, 4'd2, 4'd1, 10'b1);
    run(100, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
